// File: rtl/rx_buffer_ctrl.sv
// rx_buffer_ctrl: packs the decoded USB RX byte stream into little-endian
// 32-bit words for the endpoint RX buffer. It tracks packet completion,
// errors and overflow, flushes the buffer on abort, and serves host word
// reads through a get/valid handshake.
module rx_buffer_ctrl #(
    parameter int MAX_PACKET_BYTES = 64,
    parameter int DEPTH_WORDS      = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_byte_valid,
    input  logic [7:0]  rx_byte,
    input  logic        rx_eop,
    input  logic        rx_error,
    input  logic        host_get_word,
    input  logic        host_flush,
    input  logic [5:0]  buffer_occupancy_rx,
    output logic        store_rx_packet_data,
    output logic [31:0] rx_packet_data,
    output logic        get_rx_data,
    output logic        flush,
    output logic        host_word_valid,
    output logic        rx_packet_ready,
    output logic [6:0]  rx_byte_count,
    output logic        rx_busy,
    output logic        rx_err_flag
);

    typedef enum logic [2:0] {IDLE, RECV, LAST, DONE, ABORT} state_t;

    localparam logic [6:0] MAX_CNT   = 7'(MAX_PACKET_BYTES);
    localparam logic [6:0] DEPTH_LIM = 7'(DEPTH_WORDS);

    state_t      state, state_next;
    logic [23:0] pack;          // lanes 0..2 of the word being assembled
    logic [6:0]  byte_count;
    logic [4:0]  words_left;
    logic        err_flag;
    logic        store_q;
    logic [31:0] data_q;
    logic        get_q;
    logic        valid_q;
    logic        flush_q;

    logic [6:0]  cnt_base;
    logic [6:0]  cnt_after;
    logic [6:0]  done_count;
    logic [6:0]  wl_sum;
    logic [1:0]  lane;
    logic        occ_full;
    logic        take_byte;
    logic        store_req;
    logic [31:0] store_data;
    logic        abort_req;
    logic        abort_err;
    logic        start_pkt;
    logic        load_count;
    logic        enter_done;
    logic        issue_get;

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_next = state;
        take_byte  = 1'b0;
        store_req  = 1'b0;
        store_data = '0;
        abort_req  = 1'b0;
        abort_err  = 1'b0;
        start_pkt  = 1'b0;
        load_count = 1'b0;
        enter_done = 1'b0;
        issue_get  = 1'b0;
        done_count = byte_count;
        // A new packet starting in IDLE counts from zero.
        cnt_base   = (state == IDLE) ? 7'd0 : byte_count;
        lane       = cnt_base[1:0];
        cnt_after  = (rx_byte_valid && cnt_base != MAX_CNT) ? cnt_base + 7'd1 : cnt_base;
        occ_full   = {1'b0, buffer_occupancy_rx} >= DEPTH_LIM;

        if (host_flush) begin
            abort_req  = 1'b1;
            state_next = ABORT;
        end else begin
            unique case (state)
                IDLE, RECV: begin
                    if (state == RECV && rx_error) begin
                        abort_req = 1'b1;
                        abort_err = 1'b1;
                    end else if (rx_byte_valid && cnt_base == MAX_CNT) begin
                        // one byte beyond the packet limit
                        abort_req = 1'b1;
                        abort_err = 1'b1;
                    end else if (rx_byte_valid && lane == 2'd3 && occ_full) begin
                        // word completes but the buffer has no room for it
                        abort_req = 1'b1;
                        abort_err = 1'b1;
                    end else begin
                        start_pkt  = (state == IDLE) && (rx_byte_valid || rx_eop);
                        load_count = start_pkt || (state == RECV);
                        take_byte  = rx_byte_valid;
                        if (rx_byte_valid && lane == 2'd3) begin
                            store_req  = 1'b1;
                            store_data = {rx_byte, pack};
                        end
                        if (rx_eop) begin
                            done_count = cnt_after;
                            if (cnt_after[1:0] != 2'd0) begin
                                state_next = LAST;
                            end else begin
                                state_next = DONE;
                                enter_done = 1'b1;
                            end
                        end else if (rx_byte_valid) begin
                            state_next = RECV;
                        end
                    end
                    if (abort_req) state_next = ABORT;
                end
                LAST: begin
                    if (rx_error || occ_full) begin
                        abort_req  = 1'b1;
                        abort_err  = 1'b1;
                        state_next = ABORT;
                    end else begin
                        // upper lanes of pack are already zero
                        store_req  = 1'b1;
                        store_data = {8'h00, pack};
                        state_next = DONE;
                        enter_done = 1'b1;
                    end
                end
                DONE: begin
                    // get_q high means a read is in flight
                    issue_get = host_get_word && (words_left != 5'd0) && !get_q;
                    // last read in flight (or empty packet): leave as its valid fires
                    if (words_left == 5'd0) state_next = IDLE;
                end
                ABORT: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
        wl_sum = done_count + 7'd3;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // One-cycle strobes, all registered from the triggering cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q <= 1'b0;
            data_q  <= '0;
            get_q   <= 1'b0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            store_q <= store_req;
            if (store_req) data_q <= store_data;
            get_q   <= issue_get;
            valid_q <= get_q && !abort_req;
            flush_q <= abort_req;
        end
    end

    // Packing register, byte counter, words remaining and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pack       <= '0;
            byte_count <= '0;
            words_left <= '0;
            err_flag   <= 1'b0;
        end else if (abort_req) begin
            pack       <= '0;
            byte_count <= '0;
            words_left <= '0;
            if (abort_err) err_flag <= 1'b1;
        end else begin
            if (start_pkt)  err_flag   <= 1'b0;
            if (load_count) byte_count <= cnt_after;
            if (store_req) begin
                pack <= '0;
            end else if (take_byte) begin
                unique case (lane)
                    2'd0:    pack[7:0]   <= rx_byte;
                    2'd1:    pack[15:8]  <= rx_byte;
                    default: pack[23:16] <= rx_byte;
                endcase
            end
            if (enter_done)     words_left <= wl_sum[6:2];
            else if (issue_get) words_left <= words_left - 5'd1;
        end
    end

    assign store_rx_packet_data = store_q;
    assign rx_packet_data       = data_q;
    assign get_rx_data          = get_q;
    assign host_word_valid      = valid_q;
    assign flush                = flush_q;
    assign rx_packet_ready      = (state == DONE);
    assign rx_busy              = (state != IDLE);
    assign rx_byte_count        = byte_count;
    assign rx_err_flag          = err_flag;

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Self-checking bench for rx_buffer_ctrl: directed scenarios plus random
// packets checked against a packet-level word model.
module tb_rx_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_byte_valid;
    logic [7:0]  rx_byte;
    logic        rx_eop;
    logic        rx_error;
    logic        host_get_word;
    logic        host_flush;
    logic [5:0]  buffer_occupancy_rx;
    logic        store_rx_packet_data;
    logic [31:0] rx_packet_data;
    logic        get_rx_data;
    logic        flush;
    logic        host_word_valid;
    logic        rx_packet_ready;
    logic [6:0]  rx_byte_count;
    logic        rx_busy;
    logic        rx_err_flag;

    int checks = 0;
    int errors = 0;

    logic [31:0] store_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  pkt[$];
    int flush_cnt = 0;
    int get_cnt   = 0;
    int valid_cnt = 0;

    rx_buffer_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_byte_valid        (rx_byte_valid),
        .rx_byte              (rx_byte),
        .rx_eop               (rx_eop),
        .rx_error             (rx_error),
        .host_get_word        (host_get_word),
        .host_flush           (host_flush),
        .buffer_occupancy_rx  (buffer_occupancy_rx),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_rx_data          (get_rx_data),
        .flush                (flush),
        .host_word_valid      (host_word_valid),
        .rx_packet_ready      (rx_packet_ready),
        .rx_byte_count        (rx_byte_count),
        .rx_busy              (rx_busy),
        .rx_err_flag          (rx_err_flag)
    );

    always #5 clk = ~clk;

    // Record strobes away from the active edge.
    always @(negedge clk) begin
        if (store_rx_packet_data) store_q.push_back(rx_packet_data);
        if (flush)                flush_cnt++;
        if (get_rx_data)          get_cnt++;
        if (host_word_valid)      valid_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected buffer words: 4-byte little-endian chunks, last one zero padded.
    task automatic build_expect();
        logic [31:0] w;
        exp_q.delete();
        for (int i = 0; i < (pkt.size() + 3) / 4; i++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++)
                if (4 * i + j < pkt.size()) w = w | (32'(pkt[4 * i + j]) << (8 * j));
            exp_q.push_back(w);
        end
    endtask

    // mode 0: eop with last byte, 1: eop in its own cycle, 2: no eop.
    task automatic send_pkt(input int mode, input int gap_max);
        for (int i = 0; i < pkt.size(); i++) begin
            rx_byte_valid = 1'b1;
            rx_byte       = pkt[i];
            rx_eop        = (mode == 0) && (i == pkt.size() - 1);
            step(1);
            rx_byte_valid = 1'b0;
            rx_eop        = 1'b0;
            rx_byte       = 8'($urandom);
            if (gap_max > 0) step(int'($urandom_range(gap_max, 0)));
        end
        if (mode == 1) begin
            rx_eop = 1'b1;
            step(1);
            rx_eop = 1'b0;
        end
        step(2);
    endtask

    task automatic rand_pkt(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    endtask

    // Host reads n words with random spacing; sometimes holds the request
    // into the pending cycle, where it must be ignored.
    task automatic drain_quiet(input int n);
        for (int w = 0; w < n; w++) begin
            host_get_word = 1'b1;
            step(1);
            if ($urandom_range(1, 0) == 1) step(1);
            host_get_word = 1'b0;
            step(1);
            step(int'($urandom_range(2, 0)));
        end
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++; if (store_rx_packet_data !== 1'b0) begin errors++; $display("FAIL reset_store got=%b exp=0", store_rx_packet_data); end
        checks++; if (rx_packet_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", rx_packet_data); end
        checks++; if (get_rx_data !== 1'b0) begin errors++; $display("FAIL reset_get got=%b exp=0", get_rx_data); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (host_word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", host_word_valid); end
        checks++; if (rx_packet_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", rx_packet_ready); end
        checks++; if (rx_byte_count !== 7'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", rx_byte_count); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        checks++; if (rx_err_flag !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", rx_err_flag); end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_basic_packet();
        pkt.delete();
        pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
        pkt.push_back(8'h44); pkt.push_back(8'h55);
        store_q.delete();
        send_pkt(0, 0);
        checks++; if (store_q.size() != 2) begin errors++; $display("FAIL basic_nstores got=%0d exp=2", store_q.size()); end
        if (store_q.size() == 2) begin
            checks++; if (store_q[0] !== 32'h44332211) begin errors++; $display("FAIL basic_word0 got=%h exp=44332211", store_q[0]); end
            checks++; if (store_q[1] !== 32'h00000055) begin errors++; $display("FAIL basic_word1 got=%h exp=00000055", store_q[1]); end
        end
        checks++; if (rx_byte_count !== 7'd5) begin errors++; $display("FAIL basic_count got=%0d exp=5", rx_byte_count); end
        checks++; if (rx_packet_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", rx_packet_ready); end
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", rx_busy); end
    endtask

    // Continues from the 5-byte packet held by test_basic_packet.
    task automatic test_drain();
        host_get_word = 1'b1;
        step(1);
        host_get_word = 1'b0;
        checks++; if (get_rx_data !== 1'b1) begin errors++; $display("FAIL drain_get1 got=%b exp=1", get_rx_data); end
        checks++; if (host_word_valid !== 1'b0) begin errors++; $display("FAIL drain_early_valid got=%b exp=0", host_word_valid); end
        step(1);
        checks++; if (host_word_valid !== 1'b1 || get_rx_data !== 1'b0) begin errors++; $display("FAIL drain_valid1 got=%b/%b exp=1/0", host_word_valid, get_rx_data); end
        checks++; if (rx_packet_ready !== 1'b1) begin errors++; $display("FAIL drain_ready_mid got=%b exp=1", rx_packet_ready); end
        step(2);
        host_get_word = 1'b1;
        step(1);
        host_get_word = 1'b0;
        checks++; if (get_rx_data !== 1'b1) begin errors++; $display("FAIL drain_get2 got=%b exp=1", get_rx_data); end
        step(1);
        checks++; if (host_word_valid !== 1'b1) begin errors++; $display("FAIL drain_valid2 got=%b exp=1", host_word_valid); end
        checks++; if (rx_packet_ready !== 1'b0 || rx_busy !== 1'b0) begin errors++; $display("FAIL drain_end got=%b/%b exp=0/0", rx_packet_ready, rx_busy); end
        host_get_word = 1'b1;
        step(1);
        host_get_word = 1'b0;
        checks++; if (get_rx_data !== 1'b0) begin errors++; $display("FAIL drain_idle_get got=%b exp=0", get_rx_data); end
        step(1);
    endtask

    task automatic test_random_packets();
        int len, mode, g0, v0, n0, cnt0;
        for (int p = 0; p < 30; p++) begin
            len  = int'($urandom_range(64, 1));
            mode = int'($urandom_range(1, 0));
            rand_pkt(len);
            build_expect();
            store_q.delete();
            send_pkt(mode, int'($urandom_range(2, 0)));
            checks++; if (store_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_nstores pkt=%0d got=%0d exp=%0d", p, store_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < store_q.size(); i++) begin
                checks++; if (store_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word pkt=%0d idx=%0d got=%h exp=%h", p, i, store_q[i], exp_q[i]); end
            end
            checks++; if (rx_byte_count !== 7'(len)) begin errors++; $display("FAIL rand_count pkt=%0d got=%0d exp=%0d", p, rx_byte_count, len); end
            checks++; if (rx_packet_ready !== 1'b1 || rx_err_flag !== 1'b0) begin errors++; $display("FAIL rand_ready pkt=%0d got=%b/%b exp=1/0", p, rx_packet_ready, rx_err_flag); end
            if ($urandom_range(3, 0) == 0) begin
                cnt0 = store_q.size();
                rx_byte_valid = 1'b1; rx_byte = 8'($urandom); rx_eop = 1'b1;
                step(1);
                rx_byte_valid = 1'b0; rx_eop = 1'b0;
                step(2);
                checks++; if (rx_byte_count !== 7'(len) || store_q.size() != cnt0) begin errors++; $display("FAIL rand_done_drop pkt=%0d got=%0d/%0d exp=%0d/%0d", p, rx_byte_count, store_q.size(), len, cnt0); end
            end
            g0 = get_cnt; v0 = valid_cnt;
            n0 = exp_q.size();
            drain_quiet(n0);
            checks++; if (get_cnt - g0 != n0 || valid_cnt - v0 != n0) begin errors++; $display("FAIL rand_reads pkt=%0d got=%0d/%0d exp=%0d", p, get_cnt - g0, valid_cnt - v0, n0); end
            checks++; if (rx_busy !== 1'b0 || rx_packet_ready !== 1'b0) begin errors++; $display("FAIL rand_idle pkt=%0d got=%b/%b exp=0/0", p, rx_busy, rx_packet_ready); end
        end
    endtask

    task automatic test_overflow();
        rand_pkt(64);
        build_expect();
        store_q.delete();
        send_pkt(2, 1);
        rx_byte_valid = 1'b1; rx_byte = 8'hEE;
        step(1);
        rx_byte_valid = 1'b0;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL ovf_flush got=%b exp=1", flush); end
        checks++; if (rx_err_flag !== 1'b1 || rx_byte_count !== 7'd0 || rx_packet_ready !== 1'b0) begin errors++; $display("FAIL ovf_state got=%b/%0d/%b exp=1/0/0", rx_err_flag, rx_byte_count, rx_packet_ready); end
        checks++; if (store_q.size() != 16) begin errors++; $display("FAIL ovf_nstores got=%0d exp=16", store_q.size()); end
        for (int i = 0; i < 16 && i < store_q.size(); i++) begin
            checks++; if (store_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word idx=%0d got=%h exp=%h", i, store_q[i], exp_q[i]); end
        end
        step(1);
        checks++; if (rx_busy !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL ovf_idle got=%b/%b exp=0/0", rx_busy, flush); end
    endtask

    task automatic test_error();
        rand_pkt(6);
        build_expect();
        store_q.delete();
        send_pkt(2, 0);
        rx_error = 1'b1;
        step(1);
        rx_error = 1'b0;
        checks++; if (flush !== 1'b1 || rx_err_flag !== 1'b1) begin errors++; $display("FAIL err_abort got=%b/%b exp=1/1", flush, rx_err_flag); end
        step(2);
        checks++; if (store_q.size() != 1) begin errors++; $display("FAIL err_nstores got=%0d exp=1", store_q.size()); end
        if (store_q.size() >= 1) begin
            checks++; if (store_q[0] !== exp_q[0]) begin errors++; $display("FAIL err_word got=%h exp=%h", store_q[0], exp_q[0]); end
        end
        rx_error = 1'b1;
        step(1);
        rx_error = 1'b0;
        checks++; if (flush !== 1'b0 || rx_busy !== 1'b0) begin errors++; $display("FAIL err_idle_ignored got=%b/%b exp=0/0", flush, rx_busy); end
        rx_byte_valid = 1'b1; rx_byte = 8'hA5;
        step(1);
        rx_byte_valid = 1'b0;
        checks++; if (rx_err_flag !== 1'b0 || rx_byte_count !== 7'd1) begin errors++; $display("FAIL err_clear got=%b/%0d exp=0/1", rx_err_flag, rx_byte_count); end
        rx_eop = 1'b1;
        step(1);
        rx_eop = 1'b0;
        step(2);
        checks++; if (store_q.size() != 2 || store_q[store_q.size()-1] !== 32'h000000A5) begin errors++; $display("FAIL err_next_pkt got=%0d/%h exp=2/000000a5", store_q.size(), store_q[store_q.size()-1]); end
        drain_quiet(1);
    endtask

    task automatic test_host_flush();
        int g0;
        rand_pkt(12);
        send_pkt(0, 0);
        checks++; if (rx_packet_ready !== 1'b1) begin errors++; $display("FAIL hflush_ready got=%b exp=1", rx_packet_ready); end
        g0 = get_cnt;
        host_flush = 1'b1;
        step(1);
        host_flush = 1'b0;
        checks++; if (flush !== 1'b1 || rx_packet_ready !== 1'b0) begin errors++; $display("FAIL hflush_pulse got=%b/%b exp=1/0", flush, rx_packet_ready); end
        step(1);
        checks++; if (rx_busy !== 1'b0 || flush !== 1'b0 || get_cnt != g0) begin errors++; $display("FAIL hflush_idle got=%b/%b/%0d exp=0/0/%0d", rx_busy, flush, get_cnt, g0); end
    endtask

    task automatic test_rst_mid();
        rand_pkt(2);
        store_q.delete();
        send_pkt(2, 0);
        rst = 1'b1;
        step(1);
        checks++; if (store_rx_packet_data !== 1'b0 || flush !== 1'b0 || rx_busy !== 1'b0 || rx_byte_count !== 7'd0 || rx_packet_data !== 32'h0) begin
            errors++; $display("FAIL rstmid_outputs got=%b/%b/%b/%0d/%h exp=0/0/0/0/0", store_rx_packet_data, flush, rx_busy, rx_byte_count, rx_packet_data); end
        rst = 1'b0;
        step(1);
        rand_pkt(4);
        build_expect();
        send_pkt(0, 0);
        checks++; if (store_q.size() != 1 || store_q[0] !== exp_q[0]) begin errors++; $display("FAIL rstmid_next got=%0d/%h exp=1/%h", store_q.size(), store_q[0], exp_q[0]); end
        drain_quiet(1);
    endtask

    task automatic test_occupancy();
        int f0;
        buffer_occupancy_rx = 6'd63;
        rand_pkt(4);
        store_q.delete();
        f0 = flush_cnt;
        send_pkt(2, 0);
        checks++; if (flush_cnt - f0 != 1 || store_q.size() != 0 || rx_err_flag !== 1'b1 || rx_busy !== 1'b0) begin
            errors++; $display("FAIL occ_full_word got=%0d/%0d/%b/%b exp=1/0/1/0", flush_cnt - f0, store_q.size(), rx_err_flag, rx_busy); end
        rand_pkt(2);
        f0 = flush_cnt;
        send_pkt(0, 0);
        checks++; if (flush_cnt - f0 != 1 || store_q.size() != 0 || rx_err_flag !== 1'b1) begin
            errors++; $display("FAIL occ_full_last got=%0d/%0d/%b exp=1/0/1", flush_cnt - f0, store_q.size(), rx_err_flag); end
        buffer_occupancy_rx = 6'd62;
        rand_pkt(7);
        build_expect();
        send_pkt(1, 0);
        checks++; if (store_q.size() != 2 || rx_packet_ready !== 1'b1) begin errors++; $display("FAIL occ_room got=%0d/%b exp=2/1", store_q.size(), rx_packet_ready); end
        if (store_q.size() == 2) begin
            checks++; if (store_q[1] !== exp_q[1]) begin errors++; $display("FAIL occ_room_word got=%h exp=%h", store_q[1], exp_q[1]); end
        end
        buffer_occupancy_rx = 6'd0;
        drain_quiet(2);
    endtask

    initial begin
        rst = 1'b1;
        rx_byte_valid = 1'b0;
        rx_byte = 8'h00;
        rx_eop = 1'b0;
        rx_error = 1'b0;
        host_get_word = 1'b0;
        host_flush = 1'b0;
        buffer_occupancy_rx = 6'd0;
        test_reset();
        test_basic_packet();
        test_drain();
        test_random_packets();
        test_overflow();
        test_error();
        test_host_flush();
        test_rst_mid();
        test_occupancy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
